// File: rtl/jam_cost_server.sv
// Responder for the JAM cost-query interface: holds the 8x8 cost table and golden
// results, sequences the JAM core reset, serves one-cycle cost lookups and grades the result.
module jam_cost_server #(
    parameter int RST_HOLD = 2,
    parameter int TIMEOUT  = 10000000,
    parameter int CNT_W    = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LdValid,
    input  logic [8:0]       LdData,
    output logic             LdReady,
    output logic             JamRst,
    input  logic [2:0]       W,
    input  logic [2:0]       J,
    output logic [6:0]       Cost,
    input  logic             Valid,
    input  logic [8:0]       MinCost,
    input  logic [3:0]       MatchCount,
    output logic             Done,
    output logic             Pass,
    output logic             Timeout,
    output logic [CNT_W-1:0] CycleCount
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_SERVE,
        ST_DONE
    } state_t;

    localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [CNT_W:0]    TIMEOUT_V = (CNT_W + 1)'(TIMEOUT);
    localparam logic [6:0]        IDX_MIN   = 7'd64;
    localparam logic [6:0]        IDX_LAST  = 7'd65;

    state_t              state_q;
    state_t              state_d;
    logic [6:0]          idx_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [6:0]          cost_tbl [64];
    logic [8:0]          gold_min;
    logic [3:0]          gold_cnt;
    logic                load_fire;
    logic                timeout_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign load_fire   = (state_q == ST_LOAD) && LdValid;
    assign timeout_hit = (({1'b0, CycleCount} + (CNT_W + 1)'(1)) == TIMEOUT_V);

    always_comb begin
        state_d = state_q;
        LdReady = 1'b0;
        JamRst  = 1'b1;
        Done    = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_LOAD;
            ST_LOAD: begin
                LdReady = 1'b1;
                if (load_fire && (idx_q == IDX_LAST)) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) state_d = ST_SERVE;
            end
            ST_SERVE: begin
                JamRst = 1'b0;
                if (Valid || timeout_hit) state_d = ST_DONE;
            end
            default: Done = 1'b1;
        endcase
    end

    // Control path: state, load index, hold timer, served cost and grading flags
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            hold_q     <= '0;
            Cost       <= '0;
            Pass       <= 1'b0;
            Timeout    <= 1'b0;
            CycleCount <= '0;
        end else begin
            state_q <= state_d;
            if (load_fire) idx_q <= idx_q + 7'd1;
            if (state_q == ST_HOLD) hold_q <= hold_q + HOLD_W'(1);
            if (state_q == ST_SERVE) begin
                Cost       <= cost_tbl[{W, J}];
                CycleCount <= sat_inc(CycleCount);
                if (Valid) Pass <= (MinCost == gold_min) && (MatchCount == gold_cnt);
                else if (timeout_hit) Timeout <= 1'b1;
            end
        end
    end

    // Table and golden storage carry no reset; they are rewritten on every load
    always_ff @(posedge CLK) begin
        if (load_fire) begin
            if (idx_q < IDX_MIN) cost_tbl[idx_q[5:0]] <= LdData[6:0];
            else if (idx_q == IDX_MIN) gold_min <= LdData;
            else gold_cnt <= LdData[3:0];
        end
    end

endmodule

// File: tb/tb_jam_cost_server.sv
// Scoreboard bench for jam_cost_server: loads cost tables, checks lookups, grading,
// timeout, reset sequencing and asynchronous reset.
module tb_jam_cost_server;

    localparam logic [8:0] GOLD_MIN = 9'd100;
    localparam logic [3:0] GOLD_CNT = 4'd3;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        LdValid = 1'b0;
    logic [8:0]  LdData = '0;
    logic        LdReady;
    logic        JamRst;
    logic [2:0]  W = '0;
    logic [2:0]  J = '0;
    logic [6:0]  Cost;
    logic        Valid = 1'b0;
    logic [8:0]  MinCost = '0;
    logic [3:0]  MatchCount = '0;
    logic        Done;
    logic        Pass;
    logic        Timeout;
    logic [23:0] CycleCount;

    int          n_checks = 0;
    int          n_pass = 0;
    int          sc = 0;
    logic [6:0]  tbl [64];
    logic [6:0]  exp_q [$];
    logic [6:0]  last_cost;

    jam_cost_server #(.RST_HOLD(2), .TIMEOUT(50), .CNT_W(24)) dut (
        .CLK(CLK), .RST(RST), .LdValid(LdValid), .LdData(LdData), .LdReady(LdReady),
        .JamRst(JamRst), .W(W), .J(J), .Cost(Cost), .Valid(Valid), .MinCost(MinCost),
        .MatchCount(MatchCount), .Done(Done), .Pass(Pass), .Timeout(Timeout),
        .CycleCount(CycleCount)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    function automatic logic [8:0] load_word(input int idx);
        logic [1:0] junk;
        junk = 2'($urandom_range(0, 3));
        if (idx < 64) return {junk, tbl[idx]};
        else if (idx == 64) return GOLD_MIN;
        else return {5'b10101, GOLD_CNT};
    endfunction

    // Reset, load the whole table (optionally with gaps in LdValid) and walk through HOLD.
    task automatic load_and_hold(input bit toggle, input bit valid_in_load, input int seed);
        int idx;
        int cyc;
        int bad;
        bit v;
        for (int i = 0; i < 64; i++) tbl[i] = (seed == 0) ? 7'(i % 100) : 7'((i * seed + 7) % 128);
        exp_q.delete();
        sc = 0;
        RST = 1'b0; LdValid = 1'b0; Valid = valid_in_load;
        MinCost = GOLD_MIN; MatchCount = GOLD_CNT;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        idx = 0; cyc = 0; bad = 0; v = 1'b0;
        while (idx < 66) begin
            if (cyc > 400) begin
                $display("FAIL load_budget: only %0d words sent in %0d cycles, required 66", idx, cyc);
                break;
            end
            if (LdReady !== 1'b1) bad++;
            v = toggle ? ~v : 1'b1;
            LdValid = v;
            LdData = load_word(idx);
            if (v) idx++;
            @(negedge CLK);
            cyc++;
        end
        n_checks++; if (bad !== 0) $display("FAIL ldready_in_load: low %0d times, required 0", bad); else n_pass++;
        n_checks++; if (cyc !== (toggle ? 131 : 66)) $display("FAIL load_cycles: got %0d required %0d", cyc, toggle ? 131 : 66); else n_pass++;
        LdValid = 1'b1;
        LdData = 9'h1FF;
        n_checks++; if (LdReady !== 1'b0) $display("FAIL ldready_after_load: got %b required 0", LdReady); else n_pass++;
        n_checks++; if (JamRst !== 1'b1) $display("FAIL jamrst_hold0: got %b required 1", JamRst); else n_pass++;
        @(negedge CLK);
        n_checks++; if (JamRst !== 1'b1) $display("FAIL jamrst_hold1: got %b required 1", JamRst); else n_pass++;
        @(negedge CLK);
        n_checks++; if (JamRst !== 1'b0) $display("FAIL jamrst_serve: got %b required 0", JamRst); else n_pass++;
        LdValid = 1'b0;
        Valid = 1'b0;
        n_checks++; if (Done !== 1'b0) $display("FAIL done_at_serve: got %b required 0", Done); else n_pass++;
        n_checks++; if (CycleCount !== 24'd0) $display("FAIL cc_at_serve: got %0d required 0", CycleCount); else n_pass++;
    endtask

    task automatic serve_one(input logic [2:0] w, input logic [2:0] j, input bit vld,
                             input logic [8:0] mc, input logic [3:0] mcnt);
        logic [6:0] e;
        W = w; J = j; Valid = vld; MinCost = mc; MatchCount = mcnt;
        exp_q.push_back(tbl[{w, j}]);
        @(negedge CLK);
        Valid = 1'b0;
        sc++;
        e = exp_q.pop_front();
        last_cost = e;
        n_checks++;
        if (Cost !== e) $display("FAIL cost w=%0d j=%0d: got %0d required %0d", w, j, Cost, e);
        else n_pass++;
    endtask

    task automatic serve_random(input int n);
        for (int k = 0; k < n; k++)
            serve_one(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, 9'd0, 4'd0);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge CLK);
        n_checks++; if (LdReady !== 1'b0) $display("FAIL rst_ldready: got %b required 0", LdReady); else n_pass++;
        n_checks++; if (JamRst !== 1'b1) $display("FAIL rst_jamrst: got %b required 1", JamRst); else n_pass++;
        n_checks++; if (Cost !== 7'd0) $display("FAIL rst_cost: got %0d required 0", Cost); else n_pass++;
        n_checks++; if (Done !== 1'b0) $display("FAIL rst_done: got %b required 0", Done); else n_pass++;
        n_checks++; if (Pass !== 1'b0) $display("FAIL rst_pass: got %b required 0", Pass); else n_pass++;
        n_checks++; if (Timeout !== 1'b0) $display("FAIL rst_timeout: got %b required 0", Timeout); else n_pass++;
        n_checks++; if (CycleCount !== 24'd0) $display("FAIL rst_cc: got %0d required 0", CycleCount); else n_pass++;
    endtask

    task automatic test_back_to_back;
        load_and_hold(1'b1, 1'b1, 0);
        serve_one(3'd3, 3'd5, 1'b0, 9'd0, 4'd0);
        serve_one(3'd7, 3'd7, 1'b0, 9'd0, 4'd0);
        serve_random(6);
        n_checks++; if (CycleCount !== 24'(sc)) $display("FAIL b2b_cc: got %0d required %0d", CycleCount, sc); else n_pass++;
    endtask

    task automatic test_grade_pass;
        serve_one(3'd1, 3'd2, 1'b1, GOLD_MIN, GOLD_CNT);
        n_checks++; if (Done !== 1'b1) $display("FAIL gp_done: got %b required 1", Done); else n_pass++;
        n_checks++; if (Pass !== 1'b1) $display("FAIL gp_pass: got %b required 1", Pass); else n_pass++;
        n_checks++; if (Timeout !== 1'b0) $display("FAIL gp_timeout: got %b required 0", Timeout); else n_pass++;
        n_checks++; if (JamRst !== 1'b1) $display("FAIL gp_jamrst: got %b required 1", JamRst); else n_pass++;
        n_checks++; if (CycleCount !== 24'(sc)) $display("FAIL gp_cc: got %0d required %0d", CycleCount, sc); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            W = 3'(k + 4); J = 3'(k); Valid = 1'b1; MinCost = 9'd7; MatchCount = 4'd1;
            @(negedge CLK);
            n_checks++; if ({Done, Pass, Timeout} !== 3'b110) $display("FAIL gp_sticky: got %b required 110", {Done, Pass, Timeout}); else n_pass++;
            n_checks++; if (Cost !== last_cost) $display("FAIL gp_cost_hold: got %0d required %0d", Cost, last_cost); else n_pass++;
        end
        Valid = 1'b0;
    endtask

    task automatic test_grade_fail;
        load_and_hold(1'b0, 1'b0, 37);
        serve_random(3);
        serve_one(3'd2, 3'd6, 1'b1, 9'd101, GOLD_CNT);
        n_checks++; if (Done !== 1'b1) $display("FAIL gf_done: got %b required 1", Done); else n_pass++;
        n_checks++; if (Pass !== 1'b0) $display("FAIL gf_pass: got %b required 0", Pass); else n_pass++;
        n_checks++; if (Timeout !== 1'b0) $display("FAIL gf_timeout: got %b required 0", Timeout); else n_pass++;
        load_and_hold(1'b0, 1'b0, 21);
        serve_one(3'd0, 3'd1, 1'b1, GOLD_MIN, 4'd4);
        n_checks++; if ({Done, Pass} !== 2'b10) $display("FAIL gf_cnt: got %b required 10", {Done, Pass}); else n_pass++;
    endtask

    task automatic test_timeout;
        load_and_hold(1'b0, 1'b0, 11);
        serve_random(49);
        n_checks++; if (Done !== 1'b0) $display("FAIL to_done_early: got %b required 0", Done); else n_pass++;
        n_checks++; if (CycleCount !== 24'd49) $display("FAIL to_cc49: got %0d required 49", CycleCount); else n_pass++;
        serve_random(1);
        n_checks++; if ({Done, Timeout, Pass} !== 3'b110) $display("FAIL to_flags: got %b required 110", {Done, Timeout, Pass}); else n_pass++;
        n_checks++; if (CycleCount !== 24'd50) $display("FAIL to_cc50: got %0d required 50", CycleCount); else n_pass++;
        n_checks++; if (JamRst !== 1'b1) $display("FAIL to_jamrst: got %b required 1", JamRst); else n_pass++;
        repeat (2) begin
            W = 3'($urandom_range(0, 7)); J = 3'($urandom_range(0, 7)); Valid = 1'b1;
            MinCost = GOLD_MIN; MatchCount = GOLD_CNT;
            @(negedge CLK);
            n_checks++; if (CycleCount !== 24'd50) $display("FAIL to_cc_hold: got %0d required 50", CycleCount); else n_pass++;
            n_checks++; if ({Timeout, Pass} !== 2'b10) $display("FAIL to_frozen: got %b required 10", {Timeout, Pass}); else n_pass++;
            n_checks++; if (Cost !== last_cost) $display("FAIL to_cost_hold: got %0d required %0d", Cost, last_cost); else n_pass++;
        end
        Valid = 1'b0;
    endtask

    task automatic test_timeout_tie;
        load_and_hold(1'b0, 1'b0, 3);
        serve_random(49);
        serve_one(3'd6, 3'd2, 1'b1, GOLD_MIN, GOLD_CNT);
        n_checks++; if ({Done, Timeout, Pass} !== 3'b101) $display("FAIL tie_flags: got %b required 101", {Done, Timeout, Pass}); else n_pass++;
        n_checks++; if (CycleCount !== 24'd50) $display("FAIL tie_cc: got %0d required 50", CycleCount); else n_pass++;
    endtask

    task automatic test_reset_mid_serve;
        load_and_hold(1'b0, 1'b0, 5);
        serve_random(4);
        serve_one(3'd0, 3'd0, 1'b0, 9'd0, 4'd0);
        #2 RST = 1'b0;
        #1;
        n_checks++; if (Cost !== 7'd0) $display("FAIL ar_cost: got %0d required 0", Cost); else n_pass++;
        n_checks++; if (JamRst !== 1'b1) $display("FAIL ar_jamrst: got %b required 1", JamRst); else n_pass++;
        n_checks++; if (CycleCount !== 24'd0) $display("FAIL ar_cc: got %0d required 0", CycleCount); else n_pass++;
        n_checks++; if ({LdReady, Done, Pass, Timeout} !== 4'b0000) $display("FAIL ar_flags: got %b required 0000", {LdReady, Done, Pass, Timeout}); else n_pass++;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        n_checks++; if (LdReady !== 1'b0) $display("FAIL ar_idle: got %b required 0", LdReady); else n_pass++;
        @(negedge CLK);
        n_checks++; if (LdReady !== 1'b1) $display("FAIL ar_load: got %b required 1", LdReady); else n_pass++;
        load_and_hold(1'b0, 1'b0, 9);
        serve_random(5);
        serve_one(3'd4, 3'd4, 1'b1, GOLD_MIN, GOLD_CNT);
        n_checks++; if ({Done, Pass} !== 2'b11) $display("FAIL ar_reload_grade: got %b required 11", {Done, Pass}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_grade_pass();
        test_grade_fail();
        test_timeout();
        test_timeout_tie();
        test_reset_mid_serve();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
